// File: rtl/mem_access_unit.sv
// RV32I memory stage: one data-cache request per load/store, pipeline stall until response.
// Optional build macro MISALIGN_TRAP_EN adds misaligned_fault and suppresses misaligned requests.
module mem_access_unit #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic                   mem_read_in,
  input  logic                   mem_write_in,
  input  logic [2:0]             funct3_in,
  input  logic [31:0]            addr_in,
  input  logic [31:0]            wdata_in,
  input  logic                   stall_in,
  input  logic                   dmem_resp,
  input  logic [31:0]            dmem_rdata,
  output logic                   dmem_read,
  output logic                   dmem_write,
  output logic [31:0]            dmem_address,
  output logic [31:0]            dmem_wdata,
  output logic [3:0]             dmem_mbe,
  output logic                   mem_stall,
  output logic [31:0]            mem_addr_out,
  output logic [31:0]            orig_addr_out,
  output logic [1:0]             bit_shift_out,
  output logic [31:0]            mem_rdata_out,
  output logic [STALL_CNT_W-1:0] stall_cycles
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                   misaligned_fault
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 next_state_s;
  logic                   op_s;
  logic                   misalign_s;
  logic [31:0]            orig_r;
  logic                   rd_r;
  logic                   wr_r;
  logic [31:0]            wdata_r;
  logic [3:0]             mbe_r;
  logic [31:0]            rdata_r;
  logic [STALL_CNT_W-1:0] cnt_r;
`ifdef MISALIGN_TRAP_EN
  logic                   fault_r;
`endif

  // Byte lanes touched by an access; loads always fetch the whole word.
  function automatic logic [3:0] calc_mbe(input logic wr, input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    if (!wr) begin
      m = 4'b1111;
    end else begin
      case (f3)
        3'b000, 3'b100: m = 4'b0001 << off;
        3'b001, 3'b101: m = 4'b0011 << {off[1], 1'b0};
        default:        m = 4'b1111;
      endcase
    end
    return m;
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic calc_misalign(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      3'b000, 3'b100: mis = 1'b0;
      3'b001, 3'b101: mis = off[0];
      default:        mis = (off != 2'b00);
    endcase
    return mis;
  endfunction
`endif

  assign op_s = valid_in & (mem_read_in | mem_write_in);

  // Misalignment detect (constant low when the trap is not built in)
  always_comb begin
`ifdef MISALIGN_TRAP_EN
    misalign_s = calc_misalign(funct3_in, addr_in[1:0]);
`else
    misalign_s = 1'b0;
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; DONE waits out external stalls so the request is not reissued
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (op_s) begin
          next_state_s = misalign_s ? DONE : BUSY;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (dmem_resp) begin
          next_state_s = DONE;
        end else begin
          next_state_s = BUSY;
        end
      end
      DONE: begin
        if (stall_in) begin
          next_state_s = DONE;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Request capture and load-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      orig_r  <= 32'h0000_0000;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      wdata_r <= 32'h0000_0000;
      mbe_r   <= 4'b0000;
      rdata_r <= 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
      fault_r <= 1'b0;
`endif
    end else begin
      if (state_r == IDLE && op_s) begin
        orig_r  <= addr_in;
        rd_r    <= mem_read_in;
        wr_r    <= mem_write_in;
        wdata_r <= wdata_in << {addr_in[1:0], 3'b000};
        mbe_r   <= calc_mbe(mem_write_in, funct3_in, addr_in[1:0]);
`ifdef MISALIGN_TRAP_EN
        fault_r <= misalign_s;
`endif
      end
`ifdef MISALIGN_TRAP_EN
      else if (state_r == DONE && !stall_in) begin
        fault_r <= 1'b0;
      end
`endif
      if (state_r == BUSY && dmem_resp && rd_r) begin
        rdata_r <= dmem_rdata;
      end
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (mem_stall && (cnt_r != {STALL_CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // FSM outputs; MEM/WB fields follow addr_in only while idle with no request
  always_comb begin
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    mem_stall  = 1'b0;
    case (state_r)
      IDLE: begin
        if (op_s) begin
          mem_stall = 1'b1;
        end else begin
          mem_stall = 1'b0;
        end
      end
      BUSY: begin
        dmem_read  = rd_r;
        dmem_write = wr_r;
        mem_stall  = 1'b1;
      end
      DONE:    mem_stall = 1'b0;
      default: mem_stall = 1'b0;
    endcase
    if (state_r == IDLE && !op_s) begin
      orig_addr_out = addr_in;
    end else begin
      orig_addr_out = orig_r;
    end
    mem_addr_out  = {orig_addr_out[31:2], 2'b00};
    bit_shift_out = orig_addr_out[1:0];
  end

  assign dmem_address  = {orig_r[31:2], 2'b00};
  assign dmem_wdata    = wdata_r;
  assign dmem_mbe      = mbe_r;
  assign mem_rdata_out = rdata_r;
  assign stall_cycles  = cnt_r;
`ifdef MISALIGN_TRAP_EN
  assign misaligned_fault = (state_r == DONE) & fault_r;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single accesses plus multi-cycle sequences.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        stall_in;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        mem_stall;
  logic [31:0] mem_addr_out;
  logic [31:0] orig_addr_out;
  logic [1:0]  bit_shift_out;
  logic [31:0] mem_rdata_out;
  logic [31:0] stall_cycles;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned_fault;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rdata;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_daddr;
    logic [3:0]  exp_mbe;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [6];

  mem_access_unit #(.STALL_CNT_W(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .funct3_in(funct3_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .stall_in(stall_in), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
    .mem_stall(mem_stall), .mem_addr_out(mem_addr_out), .orig_addr_out(orig_addr_out),
    .bit_shift_out(bit_shift_out), .mem_rdata_out(mem_rdata_out),
    .stall_cycles(stall_cycles)
`ifdef MISALIGN_TRAP_EN
    , .misaligned_fault(misaligned_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    valid_in = 1'b1; mem_read_in = v.rd; mem_write_in = v.wr; funct3_in = v.f3;
    addr_in = v.addr; wdata_in = v.wdata; dmem_resp = 1'b0;
    #1;
    chk("idle_stall", {31'd0, mem_stall}, 32'd1);
    chk("idle_noreq", {31'd0, dmem_read | dmem_write}, 32'd0);
    tick();
    addr_in = 32'hFFFF_FFFF;
    wdata_in = 32'h5555_5555;
    #1;
    chk("busy_read", {31'd0, dmem_read}, {31'd0, v.rd});
    chk("busy_write", {31'd0, dmem_write}, {31'd0, v.wr});
    chk("busy_stall", {31'd0, mem_stall}, 32'd1);
    chk("dmem_address", dmem_address, v.exp_daddr);
    chk("dmem_mbe", {28'd0, dmem_mbe}, {28'd0, v.exp_mbe});
    if (v.wr) chk("dmem_wdata", dmem_wdata, v.exp_wdata);
    chk("mem_addr_out", mem_addr_out, v.exp_daddr);
    chk("orig_addr_out", orig_addr_out, v.addr);
    chk("bit_shift_out", {30'd0, bit_shift_out}, {30'd0, v.addr[1:0]});
    dmem_resp = 1'b1; dmem_rdata = v.rdata;
    tick();
    dmem_resp = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
    if (v.rd) exp_rdata = v.rdata;
    chk("done_stall", {31'd0, mem_stall}, 32'd0);
    chk("done_noreq", {31'd0, dmem_read | dmem_write}, 32'd0);
    chk("done_rdata", mem_rdata_out, exp_rdata);
    chk("done_orig", orig_addr_out, v.addr);
    valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 32'h0, 32'h0000_2000, 4'b1000, 32'hA500_0000};
    vecs[1] = '{1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234, 32'h0, 32'h0000_2000, 4'b1100, 32'h1234_0000};
    vecs[2] = '{1'b0, 1'b1, 3'b010, 32'h0000_3000, 32'hCAFE_BABE, 32'h0, 32'h0000_3000, 4'b1111, 32'hCAFE_BABE};
    vecs[3] = '{1'b0, 1'b1, 3'b000, 32'h0000_4001, 32'h0000_0077, 32'h0, 32'h0000_4000, 4'b0010, 32'h0000_7700};
    vecs[4] = '{1'b1, 1'b0, 3'b000, 32'h0000_6001, 32'h0, 32'h0102_0304, 32'h0000_6000, 4'b1111, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 3'b101, 32'h0000_7002, 32'h0, 32'hA0B0_C0D0, 32'h0000_7000, 4'b1111, 32'h0};

    rst = 1'b1; valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    funct3_in = 3'b000; addr_in = 32'h0; wdata_in = 32'h0; stall_in = 1'b0;
    dmem_resp = 1'b0; dmem_rdata = 32'h0; exp_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_req", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("rst_daddr", dmem_address, 32'd0);
    chk("rst_rdata", mem_rdata_out, 32'd0);
    chk("rst_cnt", stall_cycles, 32'd0);

    // LW with response on the third BUSY cycle
    valid_in = 1'b1; mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h1000_0004;
    #1;
    chk("lw_stall0", {31'd0, mem_stall}, 32'd1);
    tick();
    chk("lw_daddr", dmem_address, 32'h1000_0004);
    chk("lw_mbe", {28'd0, dmem_mbe}, 32'hF);
    for (int i = 0; i < 3; i++) begin
      chk("lw_busy_read", {31'd0, dmem_read}, 32'd1);
      chk("lw_busy_stall", {31'd0, mem_stall}, 32'd1);
      if (i == 2) begin
        dmem_resp = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      end
      tick();
    end
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    exp_rdata = 32'hDEAD_BEEF;
    chk("lw_rdata", mem_rdata_out, 32'hDEAD_BEEF);
    chk("lw_done_stall", {31'd0, mem_stall}, 32'd0);
    chk("lw_cnt", stall_cycles, 32'd4);
    valid_in = 1'b0; mem_read_in = 1'b0;
    tick();

    // Non-memory instruction passes through without stalling
    valid_in = 1'b1; addr_in = 32'h0000_ABCD;
    #1;
    chk("nop_stall", {31'd0, mem_stall}, 32'd0);
    chk("nop_maddr", mem_addr_out, 32'h0000_ABCC);
    chk("nop_shift", {30'd0, bit_shift_out}, 32'd1);
    chk("nop_orig", orig_addr_out, 32'h0000_ABCD);
    tick();
    chk("nop_cnt", stall_cycles, 32'd4);
    valid_in = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

`ifdef MISALIGN_TRAP_EN
    valid_in = 1'b1; mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h0000_1001;
    #1;
    chk("mis_stall0", {31'd0, mem_stall}, 32'd1);
    chk("mis_noread0", {31'd0, dmem_read}, 32'd0);
    tick();
    chk("mis_fault", {31'd0, misaligned_fault}, 32'd1);
    chk("mis_stall1", {31'd0, mem_stall}, 32'd0);
    chk("mis_noread1", {31'd0, dmem_read}, 32'd0);
    chk("mis_rdata", mem_rdata_out, exp_rdata);
    valid_in = 1'b0; mem_read_in = 1'b0;
    tick();
    chk("mis_fault_off", {31'd0, misaligned_fault}, 32'd0);
    chk("mis_noread2", {31'd0, dmem_read}, 32'd0);
`else
    run_vec('{1'b0, 1'b1, 3'b001, 32'h0000_5003, 32'h0000_BEEF, 32'h0, 32'h0000_5000, 4'b1100, 32'hEF00_0000});
`endif

    // Load completes while another stage stalls for three cycles
    valid_in = 1'b1; mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h0000_8000;
    tick();
    dmem_resp = 1'b1; dmem_rdata = 32'h1122_3344;
    stall_in = 1'b1;
    tick();
    dmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        dmem_resp = 1'b1; dmem_rdata = 32'h9999_9999;
      end else begin
        dmem_resp = 1'b0;
      end
      #1;
      chk("hold_read", {31'd0, dmem_read}, 32'd0);
      chk("hold_stall", {31'd0, mem_stall}, 32'd0);
      chk("hold_rdata", mem_rdata_out, 32'h1122_3344);
      chk("hold_maddr", mem_addr_out, 32'h0000_8000);
      tick();
    end
    dmem_resp = 1'b0;
    stall_in = 1'b0;
    tick();
    valid_in = 1'b0; mem_read_in = 1'b0; addr_in = 32'h0000_9004;
    #1;
    chk("hold_idle_maddr", mem_addr_out, 32'h0000_9004);
    chk("hold_idle_stall", {31'd0, mem_stall}, 32'd0);
    chk("hold_rdata_final", mem_rdata_out, 32'h1122_3344);
    tick();

    // Reset in the middle of a BUSY load
    valid_in = 1'b1; mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h0000_A000;
    tick();
    chk("rb_busy_read", {31'd0, dmem_read}, 32'd1);
    rst = 1'b1; valid_in = 1'b0; mem_read_in = 1'b0; addr_in = 32'h0;
    tick();
    rst = 1'b0;
    #1;
    chk("rb_read", {31'd0, dmem_read}, 32'd0);
    chk("rb_stall", {31'd0, mem_stall}, 32'd0);
    chk("rb_daddr", dmem_address, 32'd0);
    chk("rb_rdata", mem_rdata_out, 32'd0);
    chk("rb_cnt", stall_cycles, 32'd0);
    chk("rb_maddr", mem_addr_out, 32'd0);
    dmem_resp = 1'b1; dmem_rdata = 32'h7777_7777;
    tick();
    dmem_resp = 1'b0;
    chk("rb_late_rdata", mem_rdata_out, 32'd0);
    chk("rb_late_read", {31'd0, dmem_read}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
